// File: rtl/hpu_pkg.sv
// Shared encodings for the hypervector bundling datapath.
package hpu_pkg;

  localparam logic [1:0] VOTE_POS  = 2'b01;
  localparam logic [1:0] VOTE_NEG  = 2'b11;
  localparam logic [1:0] VOTE_ZERO = 2'b00;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Illegal 2'b10 falls into the default and counts as no vote
  function automatic logic signed [1:0] decode_vote(input logic [1:0] v);
    case (v)
      VOTE_POS:  decode_vote = 2'sb01;
      VOTE_NEG:  decode_vote = 2'sb11;
      VOTE_ZERO: decode_vote = 2'sb00;
      default:   decode_vote = 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/bundle_lane.sv
// One hypervector lane: vote decode, adder tree, saturating accumulator, majority threshold.
module bundle_lane
  import hpu_pkg::*;
#(
  parameter int unsigned NUM_CORE = 32,
  parameter int unsigned ACC_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  zero,
  input  logic                  en,
  input  logic [NUM_CORE*2-1:0] votes,
  input  logic                  tie,
  output logic                  maj
);

  localparam int unsigned SUM_W = $clog2(NUM_CORE + 1) + 1;

  logic signed [SUM_W-1:0] beat_sum;
  logic signed [ACC_W:0]   wide;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  // Signed sum of all core votes for this beat
  always_comb begin
    beat_sum = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      beat_sum = beat_sum + SUM_W'(decode_vote(votes[c*2 +: 2]));
    end
  end

  // One guard bit is enough since |beat_sum| < 2^(ACC_W-1)
  always_comb begin
    wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(beat_sum);
    case (wide[ACC_W -: 2])
      2'b01:   acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
      2'b10:   acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
      default: acc_sat = wide[ACC_W-1:0];
    endcase
  end

  // Next accumulator value: zeroing wins over accumulation
  always_comb begin
    acc_d = acc_q;
    if (zero) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_sat;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Threshold on the post-add value so the last beat counts
  always_comb begin
    if (acc_sat[ACC_W-1]) begin
      maj = 1'b1;
    end else if (acc_sat == '0) begin
      maj = tie;
    end else begin
      maj = 1'b0;
    end
  end

endmodule

// File: rtl/bundle_accumulator.sv
// Multi-beat majority bundler: FSM, handshake, beat counter and optional tie-break LFSR.
// Define BUNDLE_TIEBREAK_EN to break ties with LFSR bits instead of 0.
module bundle_accumulator
  import hpu_pkg::*;
#(
  parameter int unsigned DIM      = 4,
  parameter int unsigned NUM_CORE = 32,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [DIM*NUM_CORE*2-1:0] sel_bits,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIM-1:0]            out_vec,
  output logic [COUNT_W-1:0]        item_cnt
);

  state_e               state_d, state_q;
  logic                 accept, last_acc, done_take, lane_zero;
  logic [DIM-1:0]       lane_maj, tie_vec;
  logic [DIM-1:0]       vec_d, vec_q;
  logic [COUNT_W-1:0]   cnt_d, cnt_q;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign last_acc  = accept & in_last & ~clear;
  assign done_take = out_valid & out_ready;
  assign lane_zero = clear | done_take;
  assign out_vec   = vec_q;
  assign item_cnt  = cnt_q;

  for (genvar l = 0; l < DIM; l++) begin : g_lane
    bundle_lane #(
      .NUM_CORE (NUM_CORE),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .zero  (lane_zero),
      .en    (accept),
      .votes (sel_bits[l*NUM_CORE*2 +: NUM_CORE*2]),
      .tie   (tie_vec[l]),
      .maj   (lane_maj[l])
    );
  end

`ifdef BUNDLE_TIEBREAK_EN
  logic [15:0] lfsr_d, lfsr_q;

  for (genvar l = 0; l < DIM; l++) begin : g_tie
    assign tie_vec[l] = lfsr_q[l % 16];
  end

  // Advance once per completed bundle, after its ties have used the current state
  always_comb begin
    lfsr_d = lfsr_q;
    if (last_acc) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // LFSR register
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign tie_vec = '0;
`endif

  // Next-state logic; clear overrides beats and the output handshake
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = in_last ? DONE : ACC;
        ACC:     if (accept && in_last) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Beat counter and result capture
  always_comb begin
    cnt_d = cnt_q;
    vec_d = vec_q;
    if (lane_zero) begin
      cnt_d = '0;
    end else if (accept && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (last_acc) begin
      vec_d = lane_maj;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

endmodule

// File: tb/tb_bundle_accumulator.sv
// Directed self-checking bench for bundle_accumulator (DIM=4, NUM_CORE=2, ACC_W=6, COUNT_W=8).
module tb_bundle_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] sel_bits = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_vec;
  logic [7:0]  item_cnt;

  int total = 0;
  int bad = 0;

  // Lane nibble {core1, core0}
  localparam logic [3:0] PP = 4'b0101;  // (+1,+1)
  localparam logic [3:0] NN = 4'b1111;  // (-1,-1)
  localparam logic [3:0] PN = 4'b1101;  // (+1,-1)
  localparam logic [3:0] ZZ = 4'b0000;  // (0,0)
  localparam logic [3:0] PZ = 4'b0001;  // (+1,0)
  localparam logic [3:0] NZ = 4'b0011;  // (-1,0)

  bundle_accumulator #(
    .DIM      (4),
    .NUM_CORE (2),
    .ACC_W    (6),
    .COUNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .sel_bits  (sel_bits),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .item_cnt  (item_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input logic [15:0] s, input logic last);
    in_valid = 1'b1;
    sel_bits = s;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_vec !== 4'b0000) begin bad++;
      $display("FAIL reset_out_vec got=%b want=0000", out_vec); end
    total++; if (item_cnt !== 8'd0) begin bad++;
      $display("FAIL reset_item_cnt got=%0d want=0", item_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single_beat();
    do_reset();
    beat({ZZ, PN, NN, PP}, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++;
      $display("FAIL single_out_valid got=%b want=1", out_valid); end
    total++; if (out_vec !== 4'b0010) begin bad++;
      $display("FAIL single_out_vec got=%b want=0010", out_vec); end
    total++; if (item_cnt !== 8'd1) begin bad++;
      $display("FAIL single_item_cnt got=%0d want=1", item_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++;
      $display("FAIL single_in_ready got=%b want=0", in_ready); end
    take_output();
    total++; if (out_valid !== 1'b0 || item_cnt !== 8'd0) begin bad++;
      $display("FAIL single_after_take valid=%b cnt=%0d want 0/0", out_valid, item_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 40; i++) beat({PP, PP, PP, PP}, 1'b0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL sat_mid valid=%b ready=%b want 0/1", out_valid, in_ready); end
    total++; if (item_cnt !== 8'd40) begin bad++;
      $display("FAIL sat_mid_cnt got=%0d want=40", item_cnt); end
    for (int i = 0; i < 33; i++) beat({NN, NN, NN, NN}, (i == 32));
    total++; if (out_valid !== 1'b1) begin bad++;
      $display("FAIL sat_out_valid got=%b want=1", out_valid); end
    total++; if (out_vec !== 4'b1111) begin bad++;
      $display("FAIL sat_out_vec got=%b want=1111", out_vec); end
    total++; if (item_cnt !== 8'd73) begin bad++;
      $display("FAIL sat_item_cnt got=%0d want=73", item_cnt); end
    take_output();
  endtask

  task automatic test_back_to_back();
    do_reset();
    beat({PZ, NZ, PP, NN}, 1'b1);
    total++; if (out_vec !== 4'b0101 || item_cnt !== 8'd1) begin bad++;
      $display("FAIL bp_first vec=%b cnt=%0d want 0101/1", out_vec, item_cnt); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      sel_bits = {PP, PP, PP, PP};
      tick();
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++;
        $display("FAIL bp_hold_hs cyc=%0d ready=%b valid=%b want 0/1", i, in_ready, out_valid); end
      total++; if (out_vec !== 4'b0101 || item_cnt !== 8'd1) begin bad++;
        $display("FAIL bp_hold_data cyc=%0d vec=%b cnt=%0d want 0101/1", i, out_vec, item_cnt); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_output();
    beat({PZ, PZ, PZ, PZ}, 1'b1);
    total++; if (out_vec !== 4'b0000 || item_cnt !== 8'd1) begin bad++;
      $display("FAIL bp_next vec=%b cnt=%0d want 0000/1", out_vec, item_cnt); end
    take_output();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) beat({NN, NN, NN, NN}, 1'b0);
    total++; if (item_cnt !== 8'd3) begin bad++;
      $display("FAIL rmid_cnt got=%0d want=3", item_cnt); end
    do_reset();
    total++; if (out_valid !== 1'b0 || item_cnt !== 8'd0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL rmid_after valid=%b cnt=%0d ready=%b want 0/0/1",
               out_valid, item_cnt, in_ready); end
    beat({PZ, PZ, PZ, PZ}, 1'b1);
    total++; if (out_vec !== 4'b0000 || item_cnt !== 8'd1) begin bad++;
      $display("FAIL rmid_next vec=%b cnt=%0d want 0000/1", out_vec, item_cnt); end
    take_output();
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 2; i++) beat({NN, NN, NN, NN}, 1'b0);
    clear = 1'b1;
    beat({NN, NN, NN, NN}, 1'b1);
    clear = 1'b0;
    total++; if (out_valid !== 1'b0 || item_cnt !== 8'd0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL clr_beat valid=%b cnt=%0d ready=%b want 0/0/1",
               out_valid, item_cnt, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL clr_stay got=%b want=0", out_valid); end
    beat({PZ, PZ, PZ, PZ}, 1'b1);
    total++; if (out_vec !== 4'b0000 || item_cnt !== 8'd1) begin bad++;
      $display("FAIL clr_next vec=%b cnt=%0d want 0000/1", out_vec, item_cnt); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (out_valid !== 1'b0 || item_cnt !== 8'd0) begin bad++;
      $display("FAIL clr_done valid=%b cnt=%0d want 0/0", out_valid, item_cnt); end
  endtask

`ifdef BUNDLE_TIEBREAK_EN
  task automatic test_tiebreak();
    do_reset();
    beat({PN, PN, PN, PN}, 1'b1);
    total++; if (out_vec !== 4'b0001) begin bad++;
      $display("FAIL tie_first got=%b want=0001", out_vec); end
    take_output();
    // 16'hACE1 -> 16'h59C3 after one step
    beat({PN, PN, PN, PN}, 1'b1);
    total++; if (out_vec !== 4'b0011) begin bad++;
      $display("FAIL tie_second got=%b want=0011", out_vec); end
    take_output();
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_clear();
`ifdef BUNDLE_TIEBREAK_EN
    test_tiebreak();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
